step_controller: RTL and testbench

- Consumer side of the slow-clock divider. Takes the divider's slow_clk square wave, a run/manual mode switch and a raw step pushbutton.
- Produces a single-cycle processor clock-enable pulse (cpu_en) in the fast clk_in domain.
- Sits between the divider, the board I/O and the non-pipelined core. Honours the core's halt event and counts every enable pulse it issues.

---
 rtl/step_controller.sv | 167 ++++++++++++++++
 tb/tb_step_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/step_controller.sv
// step_controller: turns the slow-clock divider output, a run/step switch and
// a bouncy step pushbutton into single-cycle clock-enable pulses for the core.
// It honours the core's halt event and counts every enable pulse issued.
// Optional feature macro: STEP_AUTOREPEAT_EN (a held button auto-repeats steps).
module step_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_CYCLES   = 50_000_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt,
  output logic             cpu_en,
  output logic             halted,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  localparam int              DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            r_run_s1, r_run_s2;
  logic            r_btn_s1, r_btn_s2;
  logic            r_slow, r_slow_prev;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_btn_db;
  logic            r_press;
  logic            r_run_pulse;
  logic [CNT_W-1:0] r_step_count;
  state_t          r_state;
  state_t          w_next_state;
  logic            w_slow_rise;
  logic            w_rep_fire;

  assign w_slow_rise = r_slow & ~r_slow_prev;

  // Two-flop synchronizers for the raw switch and button; slow_clk registered plus its history flop
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_run_s1    <= 1'b0;
      r_run_s2    <= 1'b0;
      r_btn_s1    <= 1'b0;
      r_btn_s2    <= 1'b0;
      r_slow      <= 1'b0;
      r_slow_prev <= 1'b0;
    end else begin
      r_run_s1    <= run_sw;
      r_run_s2    <= r_run_s1;
      r_btn_s1    <= step_btn;
      r_btn_s2    <= r_btn_s1;
      r_slow      <= slow_clk;
      r_slow_prev <= r_slow;
    end
  end

  // Debounce: adopt the synced level after DEBOUNCE_CYCLES consecutive differing cycles; flag rising adoptions as a press
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= '0;
      r_btn_db <= 1'b0;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_btn_s2 != r_btn_db) begin
        if (r_db_cnt == DB_MAX) begin
          r_btn_db <= r_btn_s2;
          r_db_cnt <= '0;
          r_press  <= r_btn_s2;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

`ifdef STEP_AUTOREPEAT_EN
  localparam int              RP_W   = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_MAX = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] r_rep_cnt;
  logic            w_rep_arm;

  // The repeat timer only runs while idling in manual mode with the button held and nothing else happening
  assign w_rep_arm  = (r_state == S_IDLE) && !r_run_s2 && r_btn_db && !r_press && !halt;
  assign w_rep_fire = w_rep_arm && (r_rep_cnt == RP_MAX);

  // Repeat timer: restarts on every fire and whenever it is disarmed
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_cnt <= '0;
    end else if (!w_rep_arm || w_rep_fire) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + 1'b1;
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; halt overrides every other request
  always_comb begin
    w_next_state = r_state;
    if (halt && (r_state != S_HALTED)) begin
      w_next_state = S_HALTED;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_run_s2)                   w_next_state = S_RUN;
          else if (r_press || w_rep_fire) w_next_state = S_STEP;
        end
        S_STEP:   w_next_state = S_IDLE;
        S_RUN:    if (!r_run_s2) w_next_state = S_IDLE;
        S_HALTED: if (r_press && !r_run_s2) w_next_state = S_IDLE;
        default:  w_next_state = S_IDLE;
      endcase
    end
  end

  // Free-run pulse is a registered copy of slow_rise, suppressed by halt or by leaving RUN
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_run_pulse <= 1'b0;
    end else begin
      r_run_pulse <= (r_state == S_RUN) && r_run_s2 && w_slow_rise && !halt;
    end
  end

  // Pulse counter, wraps silently
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_step_count <= '0;
    end else if (cpu_en) begin
      r_step_count <= r_step_count + 1'b1;
    end
  end

  // Output decode from the current state
  always_comb begin
    cpu_en     = (r_state == S_STEP) || r_run_pulse;
    halted     = (r_state == S_HALTED);
    mode       = r_state;
    step_count = r_step_count;
  end

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20, CNT_W=4.
module tb_step_controller;

  localparam int DEB = 4;
  localparam int REP = 20;
  localparam int CW  = 4;
`ifdef STEP_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic          clk_in = 1'b0;
  logic          rst_n, slow_clk, run_sw, step_btn, halt;
  logic          cpu_en, halted;
  logic [1:0]    mode;
  logic [CW-1:0] step_count;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pulse = 0;
  bit saw_wrap = 1'b0;
  logic [CW-1:0] prev_cnt = '0;

  step_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW), .REPEAT_CYCLES(REP)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .slow_clk(slow_clk), .run_sw(run_sw),
    .step_btn(step_btn), .halt(halt), .cpu_en(cpu_en), .halted(halted),
    .mode(mode), .step_count(step_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: spec rules on plain integers, updated once per clock
  int m_run[2], m_btn[2];
  int m_slow_now, m_slow_old, m_stable, m_db, m_press, m_rep, m_mode, m_pend, m_cnt;

  always @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      m_run = '{0, 0}; m_btn = '{0, 0};
      m_slow_now = 0; m_slow_old = 0; m_stable = 0; m_db = 0; m_press = 0;
      m_rep = 0; m_mode = 0; m_pend = 0; m_cnt = 0;
    end else begin
      int run_s, btn_s, rise, press, en, nmode, fire, armed;
      run_s = m_run[1]; btn_s = m_btn[1];
      rise  = m_slow_now && !m_slow_old;
      press = m_press;
      en    = (m_mode == 2) || m_pend;
      armed = AR && m_mode == 0 && !run_s && m_db && !press && !halt;
      fire  = armed && (m_rep == REP - 1);
      nmode = m_mode;
      if (halt && m_mode != 3) nmode = 3;
      else if (m_mode == 0) nmode = run_s ? 1 : ((press || fire) ? 2 : 0);
      else if (m_mode == 2) nmode = 0;
      else if (m_mode == 1) nmode = run_s ? 1 : 0;
      else if (press && !run_s) nmode = 0;
      m_pend = (m_mode == 1) && run_s && rise && !halt;
      m_rep  = (armed && !fire) ? m_rep + 1 : 0;
      m_cnt  = (m_cnt + en) % (1 << CW);
      m_mode = nmode;
      m_press = 0;
      if (btn_s == m_db) m_stable = 0;
      else if (m_stable == DEB - 1) begin
        m_db = btn_s; m_stable = 0; m_press = btn_s;
      end else m_stable++;
      m_run[1] = m_run[0]; m_run[0] = run_sw;
      m_btn[1] = m_btn[0]; m_btn[0] = step_btn;
      m_slow_old = m_slow_now; m_slow_now = slow_clk;
    end
  end

  // Compare every cycle, away from both edges and from the stimulus updates
  always @(negedge clk_in) begin
    #2;
    chk("cpu_en", int'(cpu_en), (m_mode == 2) || m_pend);
    chk("halted", int'(halted), m_mode == 3);
    chk("mode", int'(mode), m_mode);
    chk("step_count", int'(step_count), m_cnt);
  end

  // Pulse and wrap monitor
  always @(negedge clk_in) begin
    if (rst_n && cpu_en) n_pulse++;
    if (rst_n && prev_cnt == 4'd15 && step_count == 4'd0) saw_wrap = 1'b1;
    prev_cnt = step_count;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic press_btn();
    step_btn = 1'b1; cyc(8);
    step_btn = 1'b0; cyc(8);
  endtask

  initial begin
    rst_n = 1'b0; slow_clk = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    chk("reset_mode", int'(mode), 0);
    chk("reset_count", int'(step_count), 0);

    // Free run: five slow_clk periods of 8 cycles
    n_pulse = 0;
    run_sw = 1'b1; cyc(4);
    for (int p = 0; p < 5; p++) begin
      slow_clk = 1'b1; cyc(4);
      slow_clk = 1'b0; cyc(4);
    end
    chk("run_pulses", n_pulse, 5);
    chk("run_count", int'(step_count), 5);
    chk("run_mode", int'(mode), 1);

    // Reset mid-run clears everything immediately
    rst_n = 1'b0; run_sw = 1'b0;
    #1;
    chk("midrst_cpu_en", int'(cpu_en), 0);
    chk("midrst_halted", int'(halted), 0);
    chk("midrst_mode", int'(mode), 0);
    chk("midrst_count", int'(step_count), 0);
    cyc(2);
    rst_n = 1'b1; cyc(3);
    chk("postrst_mode", int'(mode), 0);

    // Bouncy press gives one pulse
    n_pulse = 0;
    step_btn = 1'b1; cyc(1);
    step_btn = 1'b0; cyc(1);
    step_btn = 1'b1; cyc(10);
    step_btn = 1'b0; cyc(10);
    chk("bounce_pulses", n_pulse, 1);
    chk("bounce_count", int'(step_count), 1);
    chk("bounce_mode", int'(mode), 0);

    // Halt collides with a detected slow_clk rise in RUN
    run_sw = 1'b1; cyc(5);
    n_pulse = 0;
    slow_clk = 1'b1; cyc(1);
    halt = 1'b1; cyc(1);
    halt = 1'b0; cyc(3);
    chk("halt_pulses", n_pulse, 0);
    chk("halt_mode", int'(mode), 3);
    chk("halt_halted", int'(halted), 1);
    run_sw = 1'b0; slow_clk = 1'b0; cyc(4);
    chk("halt_stays", int'(mode), 3);
    press_btn();
    chk("unhalt_mode", int'(mode), 0);
    chk("unhalt_pulses", n_pulse, 0);
    chk("unhalt_count", int'(step_count), 1);

    // Seventeen manual presses wrap the 4-bit counter
    rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(2);
    n_pulse = 0; saw_wrap = 1'b0;
    for (int k = 0; k < 17; k++) press_btn();
    chk("wrap_pulses", n_pulse, 17);
    chk("wrap_count", int'(step_count), 1);
    chk("wrap_seen", int'(saw_wrap), 1);

    // Long hold: auto-repeat adds pulses only when the feature is built in
    n_pulse = 0;
    step_btn = 1'b1; cyc(56);
    step_btn = 1'b0; cyc(20);
    chk("hold_pulses", n_pulse, AR ? 3 : 1);
    chk("hold_mode", int'(mode), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
